// File: rtl/unidad_carga_almacen.sv
// Load/store unit in front of the 256x11 data memory: LOAD, STORE and optional block COPY.
// Optional feature macro: LSU_COPY_EN enables op 11 (COPY) with its states and registers.
module unidad_carga_almacen #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_base,
    input  logic [AW-1:0] req_off,
    input  logic [DW-1:0] req_data,
    input  logic [AW-1:0] req_dst,
    input  logic [AW-1:0] req_len,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout
);

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_COPY  = 2'b11;

`ifdef LSU_COPY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_STORE, ST_COPY_RD, ST_COPY_WR} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STORE} state_t;
`endif

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_eff;
    logic [DW-1:0] r_data;
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic [DW-1:0] r_rsp_data;
    logic          w_accept;
    logic          w_illegal;
    logic [AW-1:0] w_eff;

`ifdef LSU_COPY_EN
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [AW-1:0] r_cnt;
    logic [DW-1:0] r_buf;
    logic          w_copy_empty;

    assign w_illegal    = (req_op == 2'b00);
    assign w_copy_empty = (req_op == OP_COPY) && (req_len == '0);
`else
    logic w_unused_copy;

    // Without COPY, op 11 is illegal and the copy operands are ignored.
    assign w_illegal     = (req_op == 2'b00) || (req_op == OP_COPY);
    assign w_unused_copy = ^{req_dst, req_len};
`endif

    assign req_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;
    assign w_eff     = req_base + req_off;
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and memory port drive; memory signals depend only on registered state.
    always_comb begin
        w_state_nxt = r_state;
        mem_addr    = '0;
        mem_din     = '0;
        mem_we      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (req_op)
                        OP_LOAD:  w_state_nxt = ST_LOAD;
                        OP_STORE: w_state_nxt = ST_STORE;
`ifdef LSU_COPY_EN
                        OP_COPY:  w_state_nxt = (req_len != '0) ? ST_COPY_RD : ST_IDLE;
`endif
                        default:  w_state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD: begin
                mem_addr    = r_eff;
                w_state_nxt = ST_IDLE;
            end
            ST_STORE: begin
                mem_addr    = r_eff;
                mem_din     = r_data;
                mem_we      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
`ifdef LSU_COPY_EN
            ST_COPY_RD: begin
                mem_addr    = r_src;
                w_state_nxt = ST_COPY_WR;
            end
            ST_COPY_WR: begin
                mem_addr    = r_dst;
                mem_din     = r_buf;
                mem_we      = 1'b1;
                w_state_nxt = (r_cnt == AW'(1)) ? ST_IDLE : ST_COPY_RD;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand latches and response register; reset drops any in-flight response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_eff       <= '0;
            r_data      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
`ifdef LSU_COPY_EN
            r_src       <= '0;
            r_dst       <= '0;
            r_cnt       <= '0;
            r_buf       <= '0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_eff  <= w_eff;
                        r_data <= req_data;
`ifdef LSU_COPY_EN
                        r_src  <= w_eff;
                        r_dst  <= req_dst;
                        r_cnt  <= req_len;
                        if (w_copy_empty) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b0;
                            r_rsp_data  <= '0;
                        end
`endif
                        if (w_illegal) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= '0;
                        end
                    end
                end
                ST_LOAD: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_data  <= mem_dout;
                end
                ST_STORE: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_data  <= r_data;
                end
`ifdef LSU_COPY_EN
                ST_COPY_RD: begin
                    r_buf <= mem_dout;
                end
                ST_COPY_WR: begin
                    r_src <= r_src + AW'(1);
                    r_dst <= r_dst + AW'(1);
                    r_cnt <= r_cnt - AW'(1);
                    if (r_cnt == AW'(1)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_data  <= r_buf;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unidad_carga_almacen.sv
// Self-checking bench for unidad_carga_almacen: directed cases plus random requests
// checked against an array-based memory model. COPY cases depend on LSU_COPY_EN.
module tb_unidad_carga_almacen;

`ifdef LSU_COPY_EN
    localparam bit COPY_EN = 1'b1;
`else
    localparam bit COPY_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [7:0]  req_base, req_off, req_dst, req_len;
    logic [10:0] req_data;
    logic        rsp_valid;
    logic [10:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [7:0]  mem_addr;
    logic [10:0] mem_din;
    logic        mem_we;
    logic [10:0] mem_dout;

    logic [10:0] tb_mem    [256];
    logic [10:0] init_vals [256];
    logic [10:0] ref_mem   [256];
    logic        mem_init;
    int          wr_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    unidad_carga_almacen #(.AW(8), .DW(11)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_base(req_base), .req_off(req_off), .req_data(req_data),
        .req_dst(req_dst), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, synchronous write.
    assign mem_dout = tb_mem[mem_addr];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= init_vals[i];
        end else if (mem_we) begin
            tb_mem[mem_addr] <= mem_din;
        end
    end
    always @(posedge clk) if (mem_we) wr_cnt <= wr_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    // Issue one request, predict its effect from the model, then check the response.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [7:0] base,
                         input logic [7:0] off, input logic [10:0] data,
                         input logic [7:0] dst, input logic [7:0] len);
        int unsigned eff = (int'(base) + int'(off)) % 256;
        logic [10:0] exp_data = '0;
        logic        exp_err = 1'b0;
        int          exp_n = 0;
        int          exp_w = 0;
        int          n = 0;
        int          w0;
        if (op == 2'b01) begin
            exp_data = ref_mem[eff];
            exp_n = 1;
        end else if (op == 2'b10) begin
            ref_mem[eff] = data;
            exp_data = data;
            exp_n = 1;
            exp_w = 1;
        end else if (op == 2'b11 && COPY_EN) begin
            for (int i = 0; i < int'(len); i++) begin
                ref_mem[(int'(dst) + i) % 256] = ref_mem[(int'(eff) + i) % 256];
                exp_data = ref_mem[(int'(dst) + i) % 256];
            end
            exp_n = 2 * int'(len);
            exp_w = int'(len);
        end else begin
            exp_err = 1'b1;
        end
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_base = base; req_off = off;
        req_data = data; req_dst = dst; req_len = len;
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        w0 = wr_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk({tag, ".busy"}, 32'(busy), 32'(exp_n > 0));
        while (!rsp_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'(exp_n));
        chk({tag, ".data"}, 32'(rsp_data), 32'(exp_data));
        chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, ".writes"}, 32'(wr_cnt - w0), 32'(exp_w));
        chk_mem({tag, ".mem"});
    endtask

    initial begin
        rst = 1'b1; mem_init = 1'b1; req_valid = 1'b0; req_op = '0;
        req_base = '0; req_off = '0; req_data = '0; req_dst = '0; req_len = '0;
        for (int i = 0; i < 256; i++) init_vals[i] = 11'($urandom);
        init_vals[1] = 11'd42;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_vals[i];
        repeat (3) @(posedge clk);
        #1;
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.rsp_data", 32'(rsp_data), 32'd0);
        chk("reset.rsp_err", 32'(rsp_err), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.mem_we", 32'(mem_we), 32'd0);
        chk("reset.mem_addr", 32'(mem_addr), 32'd0);
        chk("reset.mem_din", 32'(mem_din), 32'd0);
        chk("reset.ready_in_rst", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_init = 1'b0;

        do_op("load1", 2'b01, 8'h00, 8'h01, 11'h000, 8'h00, 8'h00);
        chk("load1.value", 32'(rsp_data), 32'd42);
        @(posedge clk);
        #1;
        chk("load1.pulse", 32'(rsp_valid), 32'd0);
        chk("load1.hold", 32'(rsp_data), 32'd42);

        do_op("store_wrap", 2'b10, 8'hF0, 8'h15, 11'h7FF, 8'h00, 8'h00);
        chk("store_wrap.cell", 32'(tb_mem[5]), 32'h7FF);
        do_op("load_wrap", 2'b01, 8'h00, 8'h05, 11'h000, 8'h00, 8'h00);
        chk("load_wrap.value", 32'(rsp_data), 32'h7FF);

        // COPY across the top of the address space, or op 11 as illegal.
        do_op("copy3", 2'b11, 8'hFE, 8'h00, 11'h000, 8'h10, 8'h03);
        if (COPY_EN) chk("copy3.last", 32'(rsp_data), 32'(tb_mem[8'h12]));

        do_op("illegal", 2'b00, 8'h33, 8'h44, 11'h123, 8'h00, 8'h00);
        do_op("copy_len0", 2'b11, 8'h10, 8'h20, 11'h000, 8'h40, 8'h00);

        if (COPY_EN) begin
            // Abort a 5-word COPY while it writes word 2.
            @(negedge clk);
            req_valid = 1'b1; req_op = 2'b11; req_base = 8'h20; req_off = 8'h00;
            req_dst = 8'h80; req_len = 8'd5;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            chk("abort.we_in_wr2", 32'(mem_we), 32'd1);
            @(posedge clk);
            #1;
            ref_mem[8'h80] = ref_mem[8'h20];
            ref_mem[8'h81] = ref_mem[8'h21];
            chk("abort.we", 32'(mem_we), 32'd0);
            chk("abort.busy", 32'(busy), 32'd0);
            chk("abort.rsp", 32'(rsp_valid), 32'd0);
        end else begin
            // Abort a LOAD in flight.
            @(negedge clk);
            req_valid = 1'b1; req_op = 2'b01; req_base = 8'h02; req_off = 8'h03;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
            chk("abort.we", 32'(mem_we), 32'd0);
            chk("abort.busy", 32'(busy), 32'd0);
            chk("abort.rsp", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort.no_rsp", 32'(rsp_valid), 32'd0);
        chk("abort.idle", 32'(busy), 32'd0);
        chk_mem("abort.mem");

        for (int k = 0; k < 40; k++) begin
            do_op("rand", 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                  11'($urandom), 8'($urandom), 8'($urandom_range(0, 6)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/unidad_carga_almacen.md
# unidad_carga_almacen

Load/store unit sitting directly upstream of the 256×11 data memory. It takes single-beat requests from the core's execute stage (load, store, block copy) and computes the effective address as base + offset modulo 256. It sequences the memory's asynchronous-read / synchronous-write port and returns a one-cycle response pulse with the loaded or stored word.

## Interface
Parameters:
- AW, 8, address width; must match the data memory.
- DW, 11, data word width; must match the data memory.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_op  input  2  00 illegal, 01 LOAD, 10 STORE, 11 COPY.
- req_base  input  AW  base address.
- req_off  input  AW  address offset.
- req_data  input  DW  store data.
- req_dst  input  AW  COPY destination start address.
- req_len  input  AW  COPY word count.
- rsp_valid  output  1  one-cycle response pulse; no backpressure.
- rsp_data  output  DW  loaded word / stored word / last copied word.
- rsp_err  output  1  qualifies rsp_valid: illegal op.
- busy  output  1  FSM not in IDLE.
- mem_addr  output  AW  to data memory address.
- mem_din  output  DW  to data memory write data.
- mem_we  output  1  to data memory write enable.
- mem_dout  input  DW  from data memory (combinational read).

## Operation
- Handshake: a request is accepted on a rising edge where req_valid && req_ready. req_ready = (state == IDLE) && !rst.
- On accept, the unit latches:
  - eff = (req_base + req_off) mod 256; carry discarded.
  - req_data, req_dst, req_len.
- States: IDLE, LOAD, STORE, COPY_RD, COPY_WR.
- IDLE:
  - mem_we = 0, mem_addr = 0, mem_din = 0.
  - On accept: LOAD → LOAD; STORE → STORE; COPY with len ≠ 0 → COPY_RD; COPY with len = 0 → stay IDLE.
  - op 00 → stay IDLE.
- LOAD (1 cycle):
  - mem_addr = eff, mem_we = 0.
  - At exit edge: rsp_data ← mem_dout, rsp_valid ← 1, → IDLE.
- STORE (1 cycle):
  - mem_addr = eff, mem_din = latched data, mem_we = 1.
  - At exit edge: rsp_data ← latched data, rsp_valid ← 1, → IDLE.
- COPY_RD:
  - mem_addr = src, mem_we = 0.
  - At exit edge: buf ← mem_dout, → COPY_WR.
- COPY_WR:
  - mem_addr = dst, mem_din = buf, mem_we = 1.
  - At exit edge: src ← src + 1, dst ← dst + 1 (both wrap mod 256), cnt ← cnt − 1.
  - If cnt was 1: rsp_data ← buf, rsp_valid ← 1, → IDLE. Otherwise → COPY_RD.
- COPY proceeds in ascending addresses, one word at a time. Overlapping ranges with dst > src therefore propagate already-copied words; this is the defined behaviour.
- COPY with len = 0: no memory access; rsp_valid pulses the cycle after accept with rsp_data = 0, rsp_err = 0.
- Illegal op: no memory access; rsp_valid pulses the cycle after accept with rsp_err = 1, rsp_data = 0.
- rsp_err = 0 on every non-illegal response. rsp_data holds its value between responses.

## Timing
- Reset values: state IDLE; rsp_valid 0, rsp_data 0, rsp_err 0, busy 0, mem_we 0, mem_addr 0, mem_din 0. req_ready is 0 while rst is high.
- rst high at an edge aborts any operation. mem_we is 0 from the next cycle. A partially completed COPY leaves its already-written words in memory. No response is issued for the aborted request.
- LOAD / STORE latency: accept edge E0, response valid in the cycle after E1. req_ready returns high in that same cycle, so throughput is 1 request per 2 cycles.
- COPY of N words: 2N cycles busy; rsp_valid in the cycle after edge E0+2N.
- IDLE-completing requests (illegal op, len = 0): rsp_valid the cycle after E0; req_ready stays high, so back-to-back accepts are allowed.
- mem_* outputs are combinational from state and latched registers only; there is no path from req_* inputs.

## Configuration
- Macro LSU_COPY_EN, when defined: COPY_RD / COPY_WR states, src/dst/cnt/buf registers and op 11 are present.
- When undefined: those states and registers are removed, op 11 is treated as illegal (rsp_err = 1), and req_dst / req_len are ignored.

## Test plan
- Reset, then LOAD base = 0, off = 1 (mem[1] = 42) → rsp_valid one cycle, rsp_data = 42, rsp_err = 0, mem_we never high.
- STORE base = 0xF0, off = 0x15, data = 0x7FF → write at address 0x05 (wrap); a following LOAD at 0x05 returns 0x7FF.
- COPY src = 0xFE, dst = 0x10, len = 3 → words from 0xFE, 0xFF, 0x00 written to 0x10..0x12. busy for 6 cycles, rsp_data = the word from 0x00.
- op = 00 and COPY len = 0 back-to-back → two consecutive rsp_valid pulses: err = 1 then err = 0, both with data 0, no mem_we.
- rst asserted during COPY_WR of word 2 of 5 → word 2 written. mem_we is 0 from the next cycle on, no rsp_valid, and the unit is IDLE afterwards.
- Build without LSU_COPY_EN, issue op = 11 → rsp_err = 1, memory unchanged.
